// File: rtl/ysyx_24100006_axi_rd_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU AXI read-channel arbiter.
package ysyx_24100006_axi_rd_arbiter_pkg;

  // Arbiter state: idle, or a granted master in its address or data phase.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IFU_AR = 3'd1,
    S_LSU_AR = 3'd2,
    S_IFU_R  = 3'd3,
    S_LSU_R  = 3'd4
  } state_e;

  // Grant IDs, also the bit positions of the request vector.
  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // AXI response driven to a master that is not being forwarded to.
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24100006_axi_rd_arbiter_rr_pick.sv
// Two-way request picker: single requester wins outright; a tie goes to the
// master opposite last_grant when rr_en is set, else to the LSU.
module ysyx_24100006_rr_pick
  import ysyx_24100006_axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic       gnt
);

  // Pure combinational pick; caller qualifies the result with |req.
  always_comb begin
    gnt = GNT_IFU;
    case (req)
      2'b01:   gnt = GNT_IFU;
      2'b10:   gnt = GNT_LSU;
      2'b11:   gnt = rr_en ? ~last_grant : GNT_LSU;
      default: gnt = GNT_IFU;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_axi_rd_arbiter.sv
// IFU/LSU read-channel arbiter in front of the single crossbar read port.
// A grant covers a whole transaction (AR handshake through the rlast beat).
module ysyx_24100006_axi_rd_arbiter
  import ysyx_24100006_axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  input  logic              ifu_rready,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_addr_suffix,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  input  logic              lsu_rready,
  output logic              m_axi_arvalid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_addr_suffix,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  output logic              m_axi_rready,
  output logic              len_err
);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] len_q, len_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       len_err_q, len_err_d;
  logic       pick;

  ysyx_24100006_rr_pick u_pick (
    .req        ({lsu_arvalid, ifu_arvalid}),
    .last_grant (last_grant_q),
    .rr_en      (RR_EN),
    .gnt        (pick)
  );

  // State-gated muxes: only the granted master sees the crossbar, and only
  // in the phase it is in. Everything else is held at zero.
  always_comb begin
    ifu_arready   = 1'b0;
    ifu_rvalid    = 1'b0;
    ifu_rdata     = '0;
    ifu_rresp     = RESP_OKAY;
    ifu_rlast     = 1'b0;
    lsu_arready   = 1'b0;
    lsu_rvalid    = 1'b0;
    lsu_rdata     = '0;
    lsu_rresp     = RESP_OKAY;
    lsu_rlast     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_addr_suffix = 2'b00;
    m_axi_rready  = 1'b0;
    case (state_q)
      S_IFU_AR: begin
        m_axi_arvalid = ifu_arvalid;
        m_axi_araddr  = ifu_araddr;
        m_axi_arlen   = ifu_arlen;
        m_axi_arsize  = ifu_arsize;
        ifu_arready   = m_axi_arready;
      end
      S_LSU_AR: begin
        m_axi_arvalid = lsu_arvalid;
        m_axi_araddr  = lsu_araddr;
        m_axi_arlen   = lsu_arlen;
        m_axi_arsize  = lsu_arsize;
        m_addr_suffix = lsu_addr_suffix;
        lsu_arready   = m_axi_arready;
      end
      S_IFU_R: begin
        ifu_rvalid   = m_axi_rvalid;
        ifu_rdata    = m_axi_rdata;
        ifu_rresp    = m_axi_rresp;
        ifu_rlast    = m_axi_rlast;
        m_axi_rready = ifu_rready;
      end
      S_LSU_R: begin
        lsu_rvalid   = m_axi_rvalid;
        lsu_rdata    = m_axi_rdata;
        lsu_rresp    = m_axi_rresp;
        lsu_rlast    = m_axi_rlast;
        m_axi_rready = lsu_rready;
      end
      default: ;
    endcase
  end

  // Next-state: arbitrate in IDLE, latch arlen on AR handshake, count beats
  // and release on rlast (rlast wins over the beat count).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_d      = (pick == GNT_LSU) ? S_LSU_AR : S_IFU_AR;
          last_grant_d = pick;
        end
      end
      S_IFU_AR, S_LSU_AR: begin
        if (m_axi_arvalid && m_axi_arready) begin
          len_d      = m_axi_arlen;
          beat_cnt_d = 8'd0;
          state_d    = (state_q == S_LSU_AR) ? S_LSU_R : S_IFU_R;
        end
      end
      S_IFU_R, S_LSU_R: begin
        if (m_axi_rvalid && m_axi_rready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (m_axi_rlast) begin
            state_d   = S_IDLE;
            len_err_d = (beat_cnt_q != len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register all state; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_LSU;
      len_q        <= 8'd0;
      beat_cnt_q   <= 8'd0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
    end
  end

  assign len_err = len_err_q;

endmodule

// File: tb/tb_ysyx_24100006_axi_rd_arbiter.sv
// Bench for the read arbiter: instance 0 round-robin, instance 1 fixed
// priority, both compared every cycle against a transaction-level model,
// plus directed checks of the main scenarios.
module tb_ysyx_24100006_axi_rd_arbiter;

  localparam int OW = 122;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
  logic [31:0] ifu_araddr, lsu_araddr;
  logic [7:0]  ifu_arlen, lsu_arlen;
  logic [2:0]  ifu_arsize, lsu_arsize;
  logic [1:0]  lsu_addr_suffix;
  logic        m_axi_arready, m_axi_rvalid, m_axi_rlast;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  logic [1:0]       o_ifu_arready, o_ifu_rvalid, o_ifu_rlast;
  logic [1:0][31:0] o_ifu_rdata, o_lsu_rdata, o_m_araddr;
  logic [1:0][1:0]  o_ifu_rresp, o_lsu_rresp, o_m_suffix;
  logic [1:0]       o_lsu_arready, o_lsu_rvalid, o_lsu_rlast;
  logic [1:0]       o_m_arvalid, o_m_rready, o_len_err;
  logic [1:0][7:0]  o_m_arlen;
  logic [1:0][2:0]  o_m_arsize;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_24100006_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(g == 0)) u_dut (
      .clk(clk), .reset(reset),
      .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
      .ifu_arsize(ifu_arsize), .ifu_arready(o_ifu_arready[g]),
      .ifu_rvalid(o_ifu_rvalid[g]), .ifu_rdata(o_ifu_rdata[g]), .ifu_rresp(o_ifu_rresp[g]),
      .ifu_rlast(o_ifu_rlast[g]), .ifu_rready(ifu_rready),
      .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
      .lsu_arsize(lsu_arsize), .lsu_addr_suffix(lsu_addr_suffix), .lsu_arready(o_lsu_arready[g]),
      .lsu_rvalid(o_lsu_rvalid[g]), .lsu_rdata(o_lsu_rdata[g]), .lsu_rresp(o_lsu_rresp[g]),
      .lsu_rlast(o_lsu_rlast[g]), .lsu_rready(lsu_rready),
      .m_axi_arvalid(o_m_arvalid[g]), .m_axi_araddr(o_m_araddr[g]), .m_axi_arlen(o_m_arlen[g]),
      .m_axi_arsize(o_m_arsize[g]), .m_addr_suffix(o_m_suffix[g]), .m_axi_arready(m_axi_arready),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rready(o_m_rready[g]), .len_err(o_len_err[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model per instance: owner (-1 none, 0 IFU, 1 LSU), whether the
  // owner still awaits its address handshake, who won last, beats seen.
  int owner[2]     = '{-1, -1};
  bit addr_ph[2]   = '{1'b0, 1'b0};
  bit last_lsu[2]  = '{1'b1, 1'b1};
  int exp_len[2]   = '{0, 0};
  int seen[2]      = '{0, 0};
  bit err_pend[2]  = '{1'b0, 1'b0};

  // Arready grants observed on each instance, in order (0 IFU, 1 LSU).
  int seen_gnt0[$];
  int seen_gnt1[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] obs(input int k);
    return {o_ifu_arready[k], o_ifu_rvalid[k], o_ifu_rdata[k], o_ifu_rresp[k], o_ifu_rlast[k],
            o_lsu_arready[k], o_lsu_rvalid[k], o_lsu_rdata[k], o_lsu_rresp[k], o_lsu_rlast[k],
            o_m_arvalid[k], o_m_araddr[k], o_m_arlen[k], o_m_arsize[k], o_m_suffix[k],
            o_m_rready[k], o_len_err[k]};
  endfunction

  function automatic logic [OW-1:0] expect_out(input int k);
    logic iar, irv, irl, lar, lrv, lrl, mav, mrr;
    logic [31:0] ird, lrd, maa;
    logic [1:0] irr, lrr, msf;
    logic [7:0] mal;
    logic [2:0] mas;
    iar = 0; irv = 0; irl = 0; lar = 0; lrv = 0; lrl = 0; mav = 0; mrr = 0;
    ird = 0; lrd = 0; maa = 0; irr = 0; lrr = 0; msf = 0; mal = 0; mas = 0;
    if (owner[k] == 0 && addr_ph[k]) begin
      mav = ifu_arvalid; maa = ifu_araddr; mal = ifu_arlen; mas = ifu_arsize; iar = m_axi_arready;
    end else if (owner[k] == 1 && addr_ph[k]) begin
      mav = lsu_arvalid; maa = lsu_araddr; mal = lsu_arlen; mas = lsu_arsize;
      msf = lsu_addr_suffix; lar = m_axi_arready;
    end else if (owner[k] == 0) begin
      irv = m_axi_rvalid; ird = m_axi_rdata; irr = m_axi_rresp; irl = m_axi_rlast; mrr = ifu_rready;
    end else if (owner[k] == 1) begin
      lrv = m_axi_rvalid; lrd = m_axi_rdata; lrr = m_axi_rresp; lrl = m_axi_rlast; mrr = lsu_rready;
    end
    return {iar, irv, ird, irr, irl, lar, lrv, lrd, lrr, lrl, mav, maa, mal, mas, msf, mrr, err_pend[k]};
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int w;
      if (reset) begin
        owner[k] = -1; addr_ph[k] = 0; last_lsu[k] = 1; seen[k] = 0; err_pend[k] = 0;
      end else begin
        err_pend[k] = 0;
        if (owner[k] < 0) begin
          w = -1;
          if (ifu_arvalid && lsu_arvalid) w = (k == 0) ? (last_lsu[k] ? 0 : 1) : 1;
          else if (ifu_arvalid) w = 0;
          else if (lsu_arvalid) w = 1;
          if (w >= 0) begin
            owner[k] = w; addr_ph[k] = 1; last_lsu[k] = (w == 1);
          end
        end else if (addr_ph[k]) begin
          if (((owner[k] == 0) ? ifu_arvalid : lsu_arvalid) && m_axi_arready) begin
            addr_ph[k] = 0; seen[k] = 0;
            exp_len[k] = (owner[k] == 0) ? int'(ifu_arlen) : int'(lsu_arlen);
          end
        end else if (m_axi_rvalid && ((owner[k] == 0) ? ifu_rready : lsu_rready)) begin
          if (m_axi_rlast) begin
            err_pend[k] = (seen[k] != exp_len[k]);
            owner[k] = -1;
          end
          seen[k] = (seen[k] + 1) % 256;
        end
      end
    end
  endtask

  // One clock: compare both instances mid-cycle, log observed grants,
  // advance the model, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    chk("outs_rr", obs(0), expect_out(0));
    chk("outs_fp", obs(1), expect_out(1));
    if (o_ifu_arready[0]) seen_gnt0.push_back(0);
    if (o_lsu_arready[0]) seen_gnt0.push_back(1);
    if (o_ifu_arready[1]) seen_gnt1.push_back(0);
    if (o_lsu_arready[1]) seen_gnt1.push_back(1);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_arsize = 3'd2; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arlen = 0; lsu_arsize = 3'd2; lsu_rready = 0;
    lsu_addr_suffix = 0; m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
    m_axi_rresp = 0; m_axi_rlast = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle_in(); cycle(); reset = 0;
  endtask

  initial begin
    int nb;
    reset = 1; idle_in();
    @(posedge clk); #1;
    chk("reset_outs", obs(0), '0);
    cycle();
    reset = 0;

    // IFU only, single beat.
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arlen = 0; m_axi_arready = 1;
    #1 chk("t1_idle_arready", o_ifu_arready[0], 0);
    cycle();
    chk("t1_arready", o_ifu_arready[0], 1);
    chk("t1_araddr", o_m_araddr[0], 32'h8000_0000);
    cycle();
    ifu_arvalid = 0; m_axi_arready = 0; ifu_rready = 1;
    m_axi_rvalid = 1; m_axi_rdata = 32'h1234_5678; m_axi_rlast = 1;
    #1 chk("t1_rdata", o_ifu_rdata[0], 32'h1234_5678);
    chk("t1_lsu_rvalid", o_lsu_rvalid[0], 0);
    cycle();
    chk("t1_len_err", o_len_err[0], 0);
    chk("t1_idle_rready", o_m_rready[0], 0);
    m_axi_rvalid = 0; m_axi_rlast = 0;
    cycle();

    // Ties with both masters always requesting, single-beat transactions.
    do_reset();
    seen_gnt0.delete(); seen_gnt1.delete();
    ifu_arvalid = 1; lsu_arvalid = 1; m_axi_arready = 1; ifu_rready = 1; lsu_rready = 1;
    m_axi_rvalid = 1; m_axi_rlast = 1;
    repeat (9) cycle();
    chk("tie_rr_count", seen_gnt0.size(), 3);
    chk("tie_rr_first", seen_gnt0[0], 0);
    chk("tie_rr_second", seen_gnt0[1], 1);
    chk("tie_rr_third", seen_gnt0[2], 0);
    chk("tie_fp_count", seen_gnt1.size(), 3);
    chk("tie_fp_all_lsu", seen_gnt1[0] + seen_gnt1[1] + seen_gnt1[2], 3);

    // LSU 4-beat burst with an IFU request arriving mid-burst.
    do_reset();
    lsu_arvalid = 1; lsu_araddr = $urandom; lsu_arlen = 3; lsu_addr_suffix = 2'b10;
    m_axi_arready = 1;
    cycle();
    chk("t3_suffix", o_m_suffix[0], 2'b10);
    cycle();
    lsu_arvalid = 0; ifu_arvalid = 1; lsu_rready = 1; m_axi_rvalid = 1;
    nb = 0;
    for (int b = 0; b < 4; b++) begin
      m_axi_rdata = $urandom; m_axi_rlast = (b == 3);
      #1 chk("t3_ifu_blocked", o_ifu_arready[0], 0);
      chk("t3_ifu_rvalid", o_ifu_rvalid[0], 0);
      if (o_lsu_rvalid[0]) nb++;
      cycle();
    end
    chk("t3_lsu_beats", nb, 4);
    chk("t3_len_ok", o_len_err[0], 0);
    m_axi_rvalid = 0; m_axi_rlast = 0;
    #1 chk("t3_gap", o_ifu_arready[0], 0);
    cycle();
    chk("t3_ifu_granted", o_ifu_arready[0], 1);
    cycle();
    ifu_arvalid = 0; ifu_rready = 1; m_axi_rvalid = 1; m_axi_rlast = 1;
    cycle();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    cycle();

    // Slave back-pressure on AR, then master back-pressure on R.
    do_reset();
    lsu_arvalid = 1; lsu_araddr = 32'hA000_0040; lsu_arlen = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_arvalid_hold", o_m_arvalid[0], 1);
      chk("t4_araddr_hold", o_m_araddr[0], 32'hA000_0040);
      cycle();
    end
    m_axi_arready = 1; cycle();
    lsu_arvalid = 0; m_axi_arready = 0;
    m_axi_rvalid = 1; m_axi_rdata = 32'hCAFE_0001; lsu_rready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_rready_low", o_m_rready[0], 0);
      cycle();
    end
    lsu_rready = 1;
    #1 chk("t4_beat0", o_lsu_rdata[0], 32'hCAFE_0001);
    cycle();
    m_axi_rdata = 32'hCAFE_0002; m_axi_rlast = 1;
    #1 chk("t4_beat1_last", o_lsu_rlast[0], 1);
    cycle();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    chk("t4_len_ok", o_len_err[0], 0);
    cycle();

    // Early rlast: arlen 3 but last on the second beat.
    do_reset();
    lsu_arvalid = 1; lsu_arlen = 3; m_axi_arready = 1;
    cycle(); cycle();
    lsu_arvalid = 0; lsu_rready = 1; m_axi_rvalid = 1; m_axi_rlast = 0;
    cycle();
    m_axi_rlast = 1;
    cycle();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    #1 chk("t5_len_err_pulse", o_len_err[0], 1);
    cycle();
    chk("t5_len_err_clear", o_len_err[0], 0);
    cycle();

    // Reset in the middle of a 4-beat IFU burst.
    do_reset();
    ifu_arvalid = 1; ifu_arlen = 3; m_axi_arready = 1;
    cycle(); cycle();
    ifu_arvalid = 0; ifu_rready = 1; m_axi_rvalid = 1;
    cycle();
    reset = 1;
    cycle();
    chk("t6_outs_quiet", {o_ifu_rvalid[0], o_m_rready[0], o_m_arvalid[0], o_ifu_arready[0],
                          o_lsu_rvalid[0], o_lsu_arready[0]}, '0);
    reset = 0; m_axi_rvalid = 0; ifu_arvalid = 1; ifu_arlen = 0;
    cycle();
    chk("t6_regrant", o_ifu_arready[0], 1);
    cycle();
    ifu_arvalid = 0; m_axi_rvalid = 1; m_axi_rlast = 1;
    cycle();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      ifu_arvalid     = 1'($urandom_range(0, 1));
      lsu_arvalid     = 1'($urandom_range(0, 1));
      ifu_araddr      = $urandom;
      lsu_araddr      = $urandom;
      ifu_arlen       = 8'($urandom_range(0, 3));
      lsu_arlen       = 8'($urandom_range(0, 3));
      ifu_arsize      = 3'($urandom_range(0, 7));
      lsu_arsize      = 3'($urandom_range(0, 7));
      lsu_addr_suffix = 2'($urandom_range(0, 3));
      ifu_rready      = 1'($urandom_range(0, 1));
      lsu_rready      = 1'($urandom_range(0, 1));
      m_axi_arready   = 1'($urandom_range(0, 1));
      m_axi_rvalid    = 1'($urandom_range(0, 1));
      m_axi_rdata     = $urandom;
      m_axi_rresp     = 2'($urandom_range(0, 3));
      m_axi_rlast     = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
